serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift through a one-bit full-add stage LSB first.
// Optional signed-overflow output is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             s, c_next;
  logic [WIDTH-1:0] sum_full;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One-bit add cell; sum_full is the partial sum including the bit produced this cycle.
  assign s        = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_next   = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign sum_full = {s, sum_sh_q};

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    carry_d  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_full[WIDTH-1:1];
        c_d      = c_next;
        if (cnt_q == LAST_BIT) begin
          sum_d   = sum_full;
          carry_d = c_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ c_next;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 sequence plus exhaustive WIDTH=4 sweep,
// with a scoreboard queue of expected results filled at acceptance time.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, carry4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .carry(carry8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .carry(carry4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int w, input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] t;
    logic [7:0] mask;
    mask    = 8'((9'd1 << w) - 9'd1);
    t       = {1'b0, x & mask} + {1'b0, y & mask};
    e.sum   = t[7:0] & mask;
    e.carry = t[w];
    e.ovf   = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
    return e;
  endfunction

  task automatic wait_ready8();
    int n = 0;
    while (!in_ready8 && n < 40) begin tick(); n++; end
    check("in_ready8_wait", 32'(in_ready8), 1);
  endtask

  task automatic compare_head8(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum8), 32'(e.sum));
      check({tag, "_carry"}, 32'(carry8), 32'(e.carry));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
`endif
    end
  endtask

  // One full WIDTH=8 transaction: optional in_valid noise in RUN and DONE, optional backpressure.
  task automatic run_op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input int hold, input bit noise);
    int         lat;
    logic [7:0] held_sum;
    wait_ready8();
    a8 = x; b8 = y; in_valid8 = 1'b1;
    sb.push_back(model(8, x, y));
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      if (noise && lat == 3) begin
        check({tag, "_in_ready_run"}, 32'(in_ready8), 0);
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        in_valid8 = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid8 = 1'b0;
    check({tag, "_latency"}, 32'(lat), 8);
    held_sum = sum8;
    compare_head8(tag);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin in_valid8 = 1'b1; a8 = 8'(i + 1); b8 = 8'h10; end
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid8), 1);
      check({tag, "_hold_sum"}, 32'(sum8), 32'(held_sum));
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid8), 0);
    check({tag, "_idle_ready"}, 32'(in_ready8), 1);
  endtask

  task automatic run_op4(input logic [3:0] x, input logic [3:0] y);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready4 && n < 20) begin tick(); n++; end
    a4 = x; b4 = y; in_valid4 = 1'b1;
    sb.push_back(model(4, {4'h0, x}, {4'h0, y}));
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin tick(); n++; end
    check("w4_latency", 32'(n), 4);
    e = sb.pop_front();
    check("w4_sum_carry", 32'({carry4, sum4}), 32'({e.carry, e.sum[3:0]}));
`ifdef SERIAL_ADDER_OVF_EN
    check("w4_ovf", 32'(ovf4), 32'(e.ovf));
`endif
    tick();
  endtask

  initial begin
    int   n;
    bit   got;
    exp_t e;
    reset = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;

    // Reset held for two edges.
    tick();
    check("rst_in_ready", 32'(in_ready8), 0);
    tick();
    check("rst_in_ready2", 32'(in_ready8), 0);
    check("rst_out_valid", 32'(out_valid8), 0);
    check("rst_sum", 32'(sum8), 0);
    check("rst_carry", 32'(carry8), 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf8), 0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready8), 1);

    run_op8("zero", 8'h00, 8'h00, 0, 1'b0);
    run_op8("5a_33", 8'h5A, 8'h33, 0, 1'b0);
    run_op8("ff_01", 8'hFF, 8'h01, 0, 1'b0);
    run_op8("7f_01", 8'h7F, 8'h01, 0, 1'b0);
    run_op8("bp", 8'hA5, 8'h3C, 5, 1'b1);

    // Back-to-back with out_ready and in_valid held high: issue interval WIDTH+2.
    out_ready8 = 1'b1;
    wait_ready8();
    a8 = 8'h81; b8 = 8'h81; in_valid8 = 1'b1;
    sb.push_back(model(8, 8'h81, 8'h81));
    tick();
    a8 = 8'h12; b8 = 8'h34;
    n = 0; got = 1'b0;
    while (!in_ready8 && n < 40) begin
      if (out_valid8) begin compare_head8("b2b_first"); got = 1'b1; end
      tick();
      n++;
    end
    check("b2b_result_seen", 32'(got), 1);
    check("b2b_interval", 32'(n + 1), 10);
    sb.push_back(model(8, 8'h12, 8'h34));
    tick();
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 40) begin tick(); n++; end
    check("b2b_second_latency", 32'(n), 8);
    compare_head8("b2b_second");
    tick();
    out_ready8 = 1'b0;

    // Reset during the third RUN cycle discards the operation.
    wait_ready8();
    a8 = 8'h0F; b8 = 8'h01; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrun_in_ready_rst", 32'(in_ready8), 0);
    tick();
    reset = 1'b0;
    check("midrun_sum", 32'(sum8), 0);
    check("midrun_carry", 32'(carry8), 0);
    n = 0; got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) got = 1'b1;
      tick();
    end
    check("midrun_no_valid", 32'(got), 0);
    run_op8("after_rst", 8'h02, 8'h03, 0, 1'b0);

    // Exhaustive WIDTH=4 sweep.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op4(4'(x), 4'(y));
      end
    end
    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
